// File: rtl/mms_line_arb.sv
// mms_line_arb
//   Shares the single MMS memory port between I-cache line refill and D-cache
//   line refill/writeback. Arbitration is round-robin per whole cache line; each
//   granted line runs an address phase followed by BEATS data beats.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   ic_req_i/ic_addr_i            I-cache line read request and miss address
//   ic_gnt_o                      I-cache request accepted (combinational, IDLE only)
//   ic_rvalid_o/ic_done_o         I-cache read beat valid / line complete pulse
//   dc_req_i/dc_we_i/dc_addr_i    D-cache line request, 1 = writeback, line address
//   dc_wdata_i                    writeback beat selected by beat_o
//   dc_gnt_o                      D-cache request accepted (combinational, IDLE only)
//   dc_wready_o                   writeback beat consumed this cycle
//   dc_rvalid_o/dc_done_o         D-cache read beat valid / line complete pulse
//   rdata_o                       shared read beat, qualified by *_rvalid_o
//   beat_o                        current beat index
//   mem_req_o/mem_we_o/mem_addr_o memory address phase (line-aligned address)
//   mem_ready_i                   memory accepts address phase
//   mem_wvalid_o/mem_wdata_o      write beat to memory
//   mem_wready_i                  memory accepts write beat
//   mem_rvalid_i/mem_rdata_i      read beat from memory
module mms_line_arb #(
   parameter int unsigned ADDR_WD = 32,
   parameter int unsigned DATA_WD = 32,
   parameter int unsigned BEATS   = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ic_req_i,
   input  logic [ADDR_WD-1:0]       ic_addr_i,
   output logic                     ic_gnt_o,
   output logic                     ic_rvalid_o,
   output logic                     ic_done_o,
   input  logic                     dc_req_i,
   input  logic                     dc_we_i,
   input  logic [ADDR_WD-1:0]       dc_addr_i,
   input  logic [DATA_WD-1:0]       dc_wdata_i,
   output logic                     dc_gnt_o,
   output logic                     dc_wready_o,
   output logic                     dc_rvalid_o,
   output logic                     dc_done_o,
   output logic [DATA_WD-1:0]       rdata_o,
   output logic [$clog2(BEATS)-1:0] beat_o,
   output logic                     mem_req_o,
   output logic                     mem_we_o,
   output logic [ADDR_WD-1:0]       mem_addr_o,
   input  logic                     mem_ready_i,
   output logic                     mem_wvalid_o,
   output logic [DATA_WD-1:0]       mem_wdata_o,
   input  logic                     mem_wready_i,
   input  logic                     mem_rvalid_i,
   input  logic [DATA_WD-1:0]       mem_rdata_i
);

   localparam int unsigned CW  = $clog2(BEATS);
   localparam int unsigned OFF = $clog2(BEATS * DATA_WD / 8);
   // Byte-offset bits inside one cache line; cleared to form the line address.
   localparam logic [ADDR_WD-1:0] OFF_MASK = ADDR_WD'((64'd1 << OFF) - 64'd1);
   localparam logic [CW-1:0]      LAST     = CW'(BEATS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_RDATA,
      S_WDATA,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic               owner_q, owner_d;   // 1 = D-cache owns the line
   logic               prio_q,  prio_d;    // 1 = D-cache wins a tie
   logic               we_q,    we_d;
   logic [ADDR_WD-1:0] addr_q,  addr_d;
   logic [CW-1:0]      cnt_q,   cnt_d;
   logic               ic_win,  dc_win;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         prio_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         prio_q  <= prio_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      prio_d       = prio_q;
      we_d         = we_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      ic_win       = 1'b0;
      dc_win       = 1'b0;
      ic_gnt_o     = 1'b0;
      dc_gnt_o     = 1'b0;
      ic_rvalid_o  = 1'b0;
      dc_rvalid_o  = 1'b0;
      ic_done_o    = 1'b0;
      dc_done_o    = 1'b0;
      dc_wready_o  = 1'b0;
      rdata_o      = '0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wvalid_o = 1'b0;
      mem_wdata_o  = '0;
      // Counter is zero outside the data phases because it wraps at line end.
      beat_o       = cnt_q;

      case (state_q)
         S_IDLE: begin
            ic_win   = ic_req_i & (~prio_q | ~dc_req_i);
            dc_win   = dc_req_i & ( prio_q | ~ic_req_i);
            ic_gnt_o = ic_win;
            dc_gnt_o = dc_win;
            if (ic_win) begin
               owner_d = 1'b0;
               we_d    = 1'b0;
               addr_d  = ic_addr_i & ~OFF_MASK;
               state_d = S_ADDR;
            end else if (dc_win) begin
               owner_d = 1'b1;
               we_d    = dc_we_i;
               addr_d  = dc_addr_i & ~OFF_MASK;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            mem_req_o  = 1'b1;
            mem_we_o   = we_q;
            mem_addr_o = addr_q;
            if (mem_ready_i) begin
               cnt_d   = '0;
               state_d = we_q ? S_WDATA : S_RDATA;
            end
         end
         S_RDATA: begin
            if (mem_rvalid_i) begin
               rdata_o     = mem_rdata_i;
               ic_rvalid_o = ~owner_q;
               dc_rvalid_o = owner_q;
               cnt_d       = cnt_q + CW'(1);
               if (cnt_q == LAST) state_d = S_DONE;
            end
         end
         S_WDATA: begin
            mem_wvalid_o = 1'b1;
            mem_wdata_o  = dc_wdata_i;
            dc_wready_o  = mem_wready_i;
            if (mem_wready_i) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) state_d = S_DONE;
            end
         end
         S_DONE: begin
            ic_done_o = ~owner_q;
            dc_done_o = owner_q;
            prio_d    = ~owner_q;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mms_line_arb.sv
// tb_mms_line_arb
//   Directed scenarios plus randomized traffic for mms_line_arb, checked against
//   a transaction-level reference model of line arbitration and sequencing.
module tb_mms_line_arb;

   localparam int unsigned ADDR_WD    = 32;
   localparam int unsigned DATA_WD    = 32;
   localparam int unsigned BEATS      = 4;
   localparam int unsigned CW         = $clog2(BEATS);
   localparam int unsigned LINE_BYTES = BEATS * DATA_WD / 8;

   logic               clk   = 1'b0;
   logic               rst_n = 1'b1;
   logic               ic_req_i;
   logic [ADDR_WD-1:0] ic_addr_i;
   logic               ic_gnt_o, ic_rvalid_o, ic_done_o;
   logic               dc_req_i, dc_we_i;
   logic [ADDR_WD-1:0] dc_addr_i;
   logic [DATA_WD-1:0] dc_wdata_i;
   logic               dc_gnt_o, dc_wready_o, dc_rvalid_o, dc_done_o;
   logic [DATA_WD-1:0] rdata_o;
   logic [CW-1:0]      beat_o;
   logic               mem_req_o, mem_we_o;
   logic [ADDR_WD-1:0] mem_addr_o;
   logic               mem_ready_i;
   logic               mem_wvalid_o;
   logic [DATA_WD-1:0] mem_wdata_o;
   logic               mem_wready_i, mem_rvalid_i;
   logic [DATA_WD-1:0] mem_rdata_i;

   mms_line_arb #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .BEATS(BEATS)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_gnt_o(ic_gnt_o),
      .ic_rvalid_o(ic_rvalid_o), .ic_done_o(ic_done_o),
      .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i),
      .dc_wdata_i(dc_wdata_i), .dc_gnt_o(dc_gnt_o), .dc_wready_o(dc_wready_o),
      .dc_rvalid_o(dc_rvalid_o), .dc_done_o(dc_done_o),
      .rdata_o(rdata_o), .beat_o(beat_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_ready_i(mem_ready_i), .mem_wvalid_o(mem_wvalid_o),
      .mem_wdata_o(mem_wdata_o), .mem_wready_i(mem_wready_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Reference model: one line in flight at a time.
   // m_stage: 1 = address phase, 2 = data beats, 3 = completion cycle.
   bit                 m_busy, m_owner, m_we, m_prio;
   int                 m_stage, m_beat;
   logic [ADDR_WD-1:0] m_addr;
   logic [DATA_WD-1:0] wline [BEATS];

   // Observations of DUT behaviour for scenario-level checks.
   int                 grants[$];
   int                 n_ic_done, n_dc_done, n_dc_wready, n_dc_rvalid;
   logic [ADDR_WD-1:0] obs_addr;
   logic               obs_we;

   function automatic logic [ADDR_WD-1:0] line_base(input logic [ADDR_WD-1:0] a);
      return (a / ADDR_WD'(LINE_BYTES)) * ADDR_WD'(LINE_BYTES);
   endfunction

   task automatic idle_inputs();
      ic_req_i = 1'b0; ic_addr_i = '0;
      dc_req_i = 1'b0; dc_we_i = 1'b0; dc_addr_i = '0; dc_wdata_i = '0;
      mem_ready_i = 1'b0; mem_wready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_owner = 1'b0; m_we = 1'b0; m_prio = 1'b0;
      m_stage = 0; m_beat = 0; m_addr = '0;
   endtask

   // Called at a negedge with inputs set; checks outputs, advances the model,
   // and returns at the following negedge.
   task automatic tick();
      bit e_icg, e_dcg, in_addr, rd, wr;
      dc_wdata_i = wline[beat_o];
      #1;
      e_icg   = !m_busy && ic_req_i && (!m_prio || !dc_req_i);
      e_dcg   = !m_busy && dc_req_i && (m_prio || !ic_req_i);
      in_addr = m_busy && m_stage == 1;
      rd      = m_busy && m_stage == 2 && !m_we;
      wr      = m_busy && m_stage == 2 && m_we;
      chk("ic_gnt", 64'(ic_gnt_o), 64'(e_icg));
      chk("dc_gnt", 64'(dc_gnt_o), 64'(e_dcg));
      chk("mem_req", 64'(mem_req_o), 64'(in_addr));
      if (in_addr) begin
         chk("mem_addr", 64'(mem_addr_o), 64'(m_addr));
         chk("mem_we", 64'(mem_we_o), 64'(m_we));
      end
      chk("ic_rvalid", 64'(ic_rvalid_o), 64'(rd && mem_rvalid_i && !m_owner));
      chk("dc_rvalid", 64'(dc_rvalid_o), 64'(rd && mem_rvalid_i && m_owner));
      if (rd && mem_rvalid_i) chk("rdata", 64'(rdata_o), 64'(mem_rdata_i));
      chk("beat", 64'(beat_o), (m_busy && m_stage == 2) ? 64'(m_beat) : 64'(0));
      chk("mem_wvalid", 64'(mem_wvalid_o), 64'(wr));
      if (wr) chk("mem_wdata", 64'(mem_wdata_o), 64'(wline[m_beat]));
      chk("dc_wready", 64'(dc_wready_o), 64'(wr && mem_wready_i));
      chk("ic_done", 64'(ic_done_o), 64'(m_busy && m_stage == 3 && !m_owner));
      chk("dc_done", 64'(dc_done_o), 64'(m_busy && m_stage == 3 && m_owner));

      if (ic_gnt_o) grants.push_back(0);
      if (dc_gnt_o) grants.push_back(1);
      if (ic_done_o) n_ic_done++;
      if (dc_done_o) n_dc_done++;
      if (dc_wready_o) n_dc_wready++;
      if (dc_rvalid_o) n_dc_rvalid++;
      if (mem_req_o) begin
         obs_addr = mem_addr_o;
         obs_we   = mem_we_o;
      end

      if (!m_busy) begin
         if (e_icg || e_dcg) begin
            m_busy  = 1'b1;
            m_stage = 1;
            m_owner = !e_icg;
            m_we    = e_icg ? 1'b0 : dc_we_i;
            m_addr  = line_base(e_icg ? ic_addr_i : dc_addr_i);
            if (m_we) foreach (wline[i]) wline[i] = $urandom;
         end
      end else if (m_stage == 1) begin
         if (mem_ready_i) begin
            m_stage = 2;
            m_beat  = 0;
         end
      end else if (m_stage == 2) begin
         if (m_we ? mem_wready_i : mem_rvalid_i) begin
            if (m_beat == int'(BEATS) - 1) m_stage = 3;
            else m_beat++;
         end
      end else begin
         m_busy = 1'b0;
         m_prio = !m_owner;
      end
      @(negedge clk);
   endtask

   // Asserts reset mid-cycle, checks that every output drops at once, then
   // releases reset on the next negedge.
   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_ctl", 64'({ic_gnt_o, dc_gnt_o, ic_rvalid_o, dc_rvalid_o, ic_done_o,
                          dc_done_o, dc_wready_o, mem_req_o, mem_we_o, mem_wvalid_o,
                          beat_o}), 64'(0));
      chk("rst_bus", 64'(mem_addr_o | rdata_o | mem_wdata_o), 64'(0));
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Memory always ready; requests left as the caller set them.
   task automatic mem_auto(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         mem_ready_i  = 1'b1;
         mem_rvalid_i = 1'b1;
         mem_wready_i = 1'b1;
         mem_rdata_i  = $urandom;
         tick();
      end
   endtask

   initial begin
      int base;
      logic [DATA_WD-1:0] d [BEATS];
      foreach (wline[i]) wline[i] = '0;
      n_ic_done = 0; n_dc_done = 0; n_dc_wready = 0; n_dc_rvalid = 0;
      obs_addr = '0; obs_we = 1'b0;
      idle_inputs();
      model_reset();
      #2;
      apply_reset();

      // Single I-cache line read.
      base = n_ic_done;
      ic_req_i = 1'b1; ic_addr_i = 32'h0000_1234;
      tick();
      ic_req_i = 1'b0; mem_ready_i = 1'b1;
      tick();
      chk("t1_addr", 64'(obs_addr), 64'h0000_1230);
      chk("t1_we", 64'(obs_we), 64'(0));
      mem_ready_i = 1'b0;
      foreach (d[i]) d[i] = 32'hD000_0000 + DATA_WD'(i);
      for (int unsigned i = 0; i < BEATS; i++) begin
         mem_rvalid_i = 1'b1; mem_rdata_i = d[i];
         tick();
      end
      mem_rvalid_i = 1'b0;
      tick();
      tick();
      chk("t1_done", 64'(n_ic_done - base), 64'(1));

      // D-cache writeback with two stall cycles per beat.
      base = n_dc_wready;
      dc_req_i = 1'b1; dc_we_i = 1'b1; dc_addr_i = 32'h8000_001C;
      tick();
      dc_req_i = 1'b0; dc_we_i = 1'b0; mem_ready_i = 1'b1;
      tick();
      chk("t3_addr", 64'(obs_addr), 64'h8000_0010);
      chk("t3_we", 64'(obs_we), 64'(1));
      mem_ready_i = 1'b0;
      for (int unsigned b = 0; b < BEATS; b++) begin
         mem_wready_i = 1'b0; tick(); tick();
         mem_wready_i = 1'b1; tick();
      end
      mem_wready_i = 1'b0;
      tick();
      tick();
      chk("t3_wready_cnt", 64'(n_dc_wready - base), 64'(BEATS));

      // D-cache refill with a long address stall and a spurious read beat.
      base = n_dc_rvalid;
      dc_req_i = 1'b1; dc_addr_i = 32'h0000_2468;
      tick();
      dc_req_i = 1'b0;
      for (int unsigned i = 0; i < 5; i++) begin
         mem_rvalid_i = (i == 2); mem_rdata_i = $urandom;
         tick();
      end
      mem_rvalid_i = 1'b0; mem_ready_i = 1'b1;
      tick();
      mem_ready_i = 1'b0;
      for (int unsigned i = 0; i < BEATS; i++) begin
         mem_rvalid_i = 1'b1; mem_rdata_i = $urandom;
         tick();
      end
      mem_rvalid_i = 1'b0;
      tick();
      tick();
      chk("t4_rvalid_cnt", 64'(n_dc_rvalid - base), 64'(BEATS));

      // Simultaneous requests straight after reset: I, D, then I again.
      apply_reset();
      idle_inputs();
      base = grants.size();
      ic_req_i = 1'b1; ic_addr_i = 32'h0000_3000;
      dc_req_i = 1'b1; dc_addr_i = 32'h0000_4000;
      mem_auto(15);
      idle_inputs();
      mem_auto(8);
      chk("t2_ngrant", 64'(grants.size() - base), 64'(3));
      if (grants.size() >= base + 3) begin
         chk("t2_first", 64'(grants[base]), 64'(0));
         chk("t2_second", 64'(grants[base+1]), 64'(1));
         chk("t2_third", 64'(grants[base+2]), 64'(0));
      end

      // Reset during read beat 2 abandons the line; a new line then completes.
      idle_inputs();
      ic_req_i = 1'b1; ic_addr_i = 32'h0000_5554;
      tick();
      ic_req_i = 1'b0; mem_ready_i = 1'b1;
      tick();
      mem_ready_i = 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
         mem_rvalid_i = 1'b1; mem_rdata_i = $urandom;
         tick();
      end
      base = n_ic_done;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
      apply_reset();
      idle_inputs();
      ic_req_i = 1'b1; ic_addr_i = 32'h0000_6668;
      tick();
      ic_req_i = 1'b0;
      mem_auto(7);
      chk("t5_done", 64'(n_ic_done - base), 64'(1));

      // Held D-cache request: back-to-back lines, one idle cycle apart.
      idle_inputs();
      base = n_dc_done;
      dc_req_i = 1'b1; dc_addr_i = 32'h0000_7000;
      mem_auto(21);
      chk("t6_lines", 64'(n_dc_done - base), 64'(3));
      idle_inputs();
      mem_auto(8);

      // Randomized traffic with spurious memory handshakes.
      for (int unsigned i = 0; i < 4000; i++) begin
         ic_req_i     = ($urandom_range(0, 2) == 0);
         ic_addr_i    = $urandom;
         dc_req_i     = ($urandom_range(0, 2) == 0);
         dc_we_i      = $urandom_range(0, 1) == 1;
         dc_addr_i    = $urandom;
         mem_ready_i  = $urandom_range(0, 1) == 1;
         mem_rvalid_i = $urandom_range(0, 1) == 1;
         mem_wready_i = $urandom_range(0, 1) == 1;
         mem_rdata_i  = $urandom;
         tick();
      end
      idle_inputs();
      mem_auto(12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
